// File: rtl/uart_tx_buffered_if.sv
// rtl/uart_tx_buffered_if.sv - byte handshake bundle for uart_tx_buffered
//
// Purpose: groups the byte-in valid/ready handshake of the buffered UART
// transmitter.
// Signals:
//   data        8  byte to send, LSB first on the line
//   data_valid  1  producer has a byte this cycle
//   data_ready  1  transmitter holding register is empty
// Modports: master = byte producer, slave = transmitter.
interface uart_tx_buffered_if;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;

  modport master (output data, output data_valid, input data_ready);
  modport slave  (input data, input data_valid, output data_ready);
endinterface

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - oversampling 8N1 UART transmitter with one-entry holding register
//
// Purpose: serialises bytes as start bit, 8 data bits (LSB first) and
// STOP_BITS stop bits, each bit lasting OVERSAMPLE baud_edge ticks. A
// one-entry holding register lets the next byte start immediately after the
// last stop tick, giving back-to-back frames with no idle gap.
// Ports:
//   clk        system clock, posedge
//   rst        asynchronous active-low reset
//   baud_edge  single-cycle oversample tick
//   in_if      byte handshake (slave modport): data, data_valid, data_ready
//   tx         serial line, straight from a flop, idle high
//   busy       frame on the line or byte held (registered)
module uart_tx_buffered #(
  parameter int OVERSAMPLE = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                baud_edge,
  uart_tx_buffered_if.slave   in_if,
  output logic                tx,
  output logic                busy
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q;
  logic          hold_full_q, hold_full_d;
  logic          tx_d, busy_d;
  logic          tick_last, stop_last, frame_end, load, accept;

  assign tick_last = (tick_q == TICK_LAST);
  assign stop_last = (stop_q == STOP_LAST);
  assign frame_end = (state_q == S_STOP) && tick_last && stop_last;

  // The holding register only empties on a baud tick that starts a frame:
  // either from idle or straight out of the last stop tick.
  assign load   = baud_edge && hold_full_q && ((state_q == S_IDLE) || frame_end);
  assign accept = in_if.data_valid && !hold_full_q;

  assign in_if.data_ready = !hold_full_q;

  // accept and load are mutually exclusive (accept needs empty, load needs full)
  always_comb begin
    hold_full_d = hold_full_q;
    if (accept)
      hold_full_d = 1'b1;
    else if (load)
      hold_full_d = 1'b0;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic; the FSM only moves on baud ticks
  always_comb begin
    state_d = state_q;
    if (baud_edge) begin
      case (state_q)
        S_IDLE:  if (hold_full_q) state_d = S_START;
        S_START: if (tick_last) state_d = S_DATA;
        S_DATA:  if (tick_last && bit_q == 3'd7) state_d = S_STOP;
        S_STOP:  if (frame_end) state_d = hold_full_q ? S_START : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath / output next values
  always_comb begin
    tick_d  = tick_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    tx_d    = tx;
    if (baud_edge) begin
      case (state_q)
        S_IDLE: begin
          tx_d = 1'b1;
          if (load) begin
            shift_d = hold_q;
            tx_d    = 1'b0;
            tick_d  = '0;
          end
        end
        S_START: begin
          if (tick_last) begin
            tick_d = '0;
            bit_d  = 3'd0;
            tx_d   = shift_q[0];
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_last) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == 3'd7) begin
              tx_d   = 1'b1;
              stop_d = 1'b0;
            end else begin
              bit_d = bit_q + 3'd1;
              tx_d  = shift_q[1];
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_last) begin
            tick_d = '0;
            if (stop_last) begin
              if (load) begin
                shift_d = hold_q;
                tx_d    = 1'b0;
              end
            end else begin
              stop_d = stop_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: begin
          tx_d   = 1'b1;
          tick_d = '0;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE) || hold_full_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q      <= '0;
      bit_q       <= 3'd0;
      stop_q      <= 1'b0;
      shift_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      tx          <= 1'b1;
      busy        <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      stop_q      <= stop_d;
      shift_q     <= shift_d;
      hold_full_q <= hold_full_d;
      tx          <= tx_d;
      busy        <= busy_d;
      if (accept)
        hold_q <= in_if.data;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;
  localparam int OS = 8;

  typedef logic [7:0] bq_t[$];
  typedef logic       lq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic baud_edge = 1'b0;
  int   baud_div = 1;
  logic tx1, busy1, tx2, busy2;
  logic cap_en = 1'b1;
  lq_t  line1, line2;
  int   total = 0;
  int   bad = 0;
  int   sends_lost = 0;

  uart_tx_buffered_if if1 ();
  uart_tx_buffered_if if2 ();

  uart_tx_buffered #(.OVERSAMPLE(OS), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .baud_edge(baud_edge), .in_if(if1), .tx(tx1), .busy(busy1));
  uart_tx_buffered #(.OVERSAMPLE(OS), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .baud_edge(baud_edge), .in_if(if2), .tx(tx2), .busy(busy2));

  always #5 clk = ~clk;

  // baud tick generator: one tick every baud_div clocks
  initial begin
    int bcnt = 0;
    forever begin
      @(negedge clk);
      bcnt++;
      if (bcnt >= baud_div) bcnt = 0;
      baud_edge = (bcnt == 0);
    end
  end

  // line capture: one sample per baud tick, just after the clock edge
  always @(posedge clk) begin
    if (baud_edge && cap_en) begin
      #1;
      line1.push_back(tx1);
      line2.push_back(tx2);
    end
  end

  function automatic int first_zero(input lq_t q);
    for (int i = 0; i < q.size(); i++)
      if (q[i] === 1'b0) return i;
    return -1;
  endfunction

  // reference waveform: every bit held OS ticks, frames concatenated
  function automatic int wave_mismatch(input lq_t q, input bq_t bytes, input int stop, input int tail);
    lq_t e;
    int  s, m, idx;
    logic expv;
    e = {};
    m = 0;
    foreach (bytes[k]) begin
      repeat (OS) e.push_back(1'b0);
      for (int b = 0; b < 8; b++) repeat (OS) e.push_back(bytes[k][b]);
      repeat (OS * stop) e.push_back(1'b1);
    end
    s = first_zero(q);
    if (s < 0) return e.size() + tail;
    for (int i = 0; i < s; i++) if (q[i] !== 1'b1) m++;
    for (int i = 0; i < e.size() + tail; i++) begin
      idx  = s + i;
      expv = (i < e.size()) ? e[i] : 1'b1;
      if (idx >= q.size() || q[idx] !== expv) m++;
    end
    return m;
  endfunction

  // receiver model: centre-samples each bit of every frame found on the line
  function automatic void decode(input lq_t q, input int stop, output bq_t got, output int ferr);
    logic [7:0] b;
    int i;
    got  = {};
    ferr = 0;
    i    = 0;
    while (i < q.size()) begin
      if (q[i] === 1'b0) begin
        if (i + (9 + stop) * OS > q.size()) break;
        if (q[i + OS / 2] !== 1'b0) ferr++;
        for (int k = 0; k < 8; k++) b[k] = q[i + OS * (k + 1) + OS / 2];
        for (int st = 0; st < stop; st++)
          if (q[i + OS * (9 + st) + OS / 2] !== 1'b1) ferr++;
        got.push_back(b);
        i = i + OS * (8 + stop) + OS / 2;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic clear_lines();
    line1.delete();
    line2.delete();
  endtask

  task automatic send(input int sel, input logic [7:0] d);
    int  n = 0;
    logic rdy;
    if (sel == 0) begin if1.data = d; if1.data_valid = 1'b1; end
    else          begin if2.data = d; if2.data_valid = 1'b1; end
    while (n < 5000) begin
      rdy = (sel == 0) ? if1.data_ready : if2.data_ready;
      if (rdy === 1'b1) break;
      @(negedge clk);
      n++;
    end
    if (n >= 5000) sends_lost++;
    @(negedge clk);
    if (sel == 0) if1.data_valid = 1'b0;
    else          if2.data_valid = 1'b0;
  endtask

  task automatic wait_idle(input int sel, output bit ok);
    int n = 0;
    while (((sel == 0) ? busy1 : busy2) !== 1'b0 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 30000);
    repeat (10 * baud_div + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    if1.data = 8'h00; if1.data_valid = 1'b0;
    if2.data = 8'h00; if2.data_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (tx1 !== 1'b1) begin bad++; $display("FAIL reset_tx got %b want 1", tx1); end
    total++; if (if1.data_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", if1.data_ready); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy1); end
    total++; if (tx2 !== 1'b1) begin bad++; $display("FAIL reset_tx2 got %b want 1", tx2); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    int cnt = 0;
    int m;
    bit ok;
    baud_div = 4;
    repeat (8) @(negedge clk);
    clear_lines();
    @(posedge clk iff baud_edge);
    repeat (3) @(negedge clk);
    if1.data = 8'hA5; if1.data_valid = 1'b1;
    for (int j = 0; j < 2000; j++) begin
      @(negedge clk);
      if (j == 0) begin
        if1.data_valid = 1'b0;
        total++; if (if1.data_ready !== 1'b0) begin bad++; $display("FAIL single_ready_low got %b want 0", if1.data_ready); end
      end
      if (j == 1) begin
        total++; if (if1.data_ready !== 1'b1) begin bad++; $display("FAIL single_ready_back got %b want 1", if1.data_ready); end
      end
      if (busy1 === 1'b1) cnt++;
      else break;
    end
    total++; if (cnt !== 1 + 80 * 4) begin bad++; $display("FAIL single_busy_cycles got %0d want %0d", cnt, 1 + 80 * 4); end
    wait_idle(0, ok);
    m = wave_mismatch(line1, '{8'hA5}, 1, 8);
    total++; if (m !== 0) begin bad++; $display("FAIL single_wave got %0d bad ticks want 0", m); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int s, m;
    bit ok;
    baud_div = 1;
    repeat (4) @(negedge clk);
    clear_lines();
    send(0, 8'h00);
    send(0, 8'hFF);
    while (if1.data_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    s = first_zero(line1);
    total++; if (line1.size() - s !== 81) begin bad++; $display("FAIL b2b_ready_timing got %0d ticks want 81", line1.size() - s); end
    total++; if (line1[line1.size() - 1] !== 1'b0) begin bad++; $display("FAIL b2b_second_start got %b want 0", line1[line1.size() - 1]); end
    wait_idle(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_idle got busy want idle"); end
    m = wave_mismatch(line1, '{8'h00, 8'hFF}, 1, 8);
    total++; if (m !== 0) begin bad++; $display("FAIL b2b_wave got %0d bad ticks want 0", m); end
  endtask

  task automatic test_holding();
    int s, m;
    bit ok;
    baud_div = 2;
    repeat (4) @(negedge clk);
    clear_lines();
    send(0, 8'h11);
    send(0, 8'h22);
    send(0, 8'h33);
    s = first_zero(line1);
    total++; if (line1.size() - s < 81) begin bad++; $display("FAIL hold_early_accept got %0d ticks want >=81", line1.size() - s); end
    wait_idle(0, ok);
    m = wave_mismatch(line1, '{8'h11, 8'h22, 8'h33}, 1, 8);
    total++; if (m !== 0) begin bad++; $display("FAIL hold_wave got %0d bad ticks want 0", m); end
  endtask

  task automatic test_stop2();
    int s, m;
    bit ok;
    baud_div = 1;
    repeat (4) @(negedge clk);
    clear_lines();
    send(1, 8'h80);
    send(1, 8'hC3);
    wait_idle(1, ok);
    s = first_zero(line2);
    total++; if (line2[s + 8 * OS + OS + 15] !== 1'b1) begin bad++; $display("FAIL stop2_last_stop got %b want 1", line2[s + 8 * OS + OS + 15]); end
    total++; if (line2[s + 8 * OS + OS + 16] !== 1'b0) begin bad++; $display("FAIL stop2_next_start got %b want 0", line2[s + 8 * OS + OS + 16]); end
    m = wave_mismatch(line2, '{8'h80, 8'hC3}, 2, 8);
    total++; if (m !== 0) begin bad++; $display("FAIL stop2_wave got %0d bad ticks want 0", m); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int s, m;
    bit ok;
    baud_div = 4;
    repeat (8) @(negedge clk);
    clear_lines();
    send(0, 8'h3C);
    send(0, 8'h99);
    s = first_zero(line1);
    while ((s < 0 || line1.size() < s + 20) && n < 3000) begin
      @(negedge clk);
      s = first_zero(line1);
      n++;
    end
    total++; if (tx1 !== 1'b0) begin bad++; $display("FAIL midreset_pre_tx got %b want 0", tx1); end
    #2 rst = 1'b0;
    #1;
    total++; if (tx1 !== 1'b1) begin bad++; $display("FAIL midreset_tx got %b want 1", tx1); end
    total++; if (if1.data_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got %b want 1", if1.data_ready); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL midreset_busy got %b want 0", busy1); end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    clear_lines();
    send(0, 8'h5A);
    wait_idle(0, ok);
    m = wave_mismatch(line1, '{8'h5A}, 1, 8);
    total++; if (m !== 0) begin bad++; $display("FAIL midreset_clean_frame got %0d bad ticks want 0", m); end
  endtask

  task automatic test_random();
    bq_t sent, got;
    int  ferr;
    bit  ok;
    logic [7:0] b;
    sent = {};
    baud_div = $urandom_range(1, 4);
    repeat (8) @(negedge clk);
    clear_lines();
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 60)) @(negedge clk);
      b = 8'($urandom);
      sent.push_back(b);
      send(0, b);
    end
    wait_idle(0, ok);
    decode(line1, 1, got, ferr);
    total++; if (got.size() !== sent.size()) begin bad++; $display("FAIL random_count got %0d want %0d", got.size(), sent.size()); end
    total++; if (ferr !== 0) begin bad++; $display("FAIL random_framing got %0d want 0", ferr); end
    for (int i = 0; i < sent.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== sent[i]) begin bad++; $display("FAIL random_byte%0d got %h want %h", i, got[i], sent[i]); end
    end
  endtask

  task automatic test_loopback();
    bq_t sent, got;
    int  ferr, errs, m;
    bit  ok;
    sent = {};
    errs = 0;
    baud_div = 1;
    repeat (4) @(negedge clk);
    clear_lines();
    for (int i = 0; i < 256; i++) begin
      sent.push_back(8'(i));
      send(0, 8'(i));
    end
    wait_idle(0, ok);
    decode(line1, 1, got, ferr);
    total++; if (got.size() !== 256) begin bad++; $display("FAIL loop_count got %0d want 256", got.size()); end
    total++; if (ferr !== 0) begin bad++; $display("FAIL loop_framing got %0d want 0", ferr); end
    for (int i = 0; i < 256 && i < got.size(); i++) if (got[i] !== sent[i]) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL loop_bytes got %0d wrong want 0", errs); end
    m = wave_mismatch(line1, sent, 1, 8);
    total++; if (m !== 0) begin bad++; $display("FAIL loop_contiguous got %0d bad ticks want 0", m); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_holding();
    test_stop2();
    test_reset_mid();
    test_random();
    test_loopback();
    total++; if (sends_lost !== 0) begin bad++; $display("FAIL handshake_timeouts got %0d want 0", sends_lost); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
